// File: rtl/post_process_pipe_if.sv
// Beat-level handshake bundle for post_process_pipe: input beat (data/ch/mode) and output beat, valid/ready each way.
// master drives input beats and output ready; slave is the pipeline.
interface post_process_pipe_if #(
    parameter int POX   = 3,
    parameter int DW    = 16,
    parameter int CH_AW = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [POX*DW-1:0]   in_data;
    logic [CH_AW-1:0]    in_ch;
    logic [1:0]          in_mode;
    logic                out_valid;
    logic                out_ready;
    logic [POX*DW-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_ch, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_ch, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/post_process_pipe.sv
// Per-channel bias add, optional ReLU, batch-norm y=x*K+B over POX lanes; signed saturating, 3-cycle latency, 1 beat/cycle.
// Output stall freezes all stages (in_ready = !out_valid || out_ready); POSTPROC_ROUND_EN selects round-half-up before the BN shift.
module post_process_pipe #(
    parameter int POX      = 3,
    parameter int DW       = 16,
    parameter int INT_BITS = 3,
    parameter int CH_DEPTH = 16,
    parameter int CH_AW    = $clog2(CH_DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [CH_AW-1:0]   cfg_addr,
    input  logic [DW-1:0]      cfg_bias,
    input  logic [DW-1:0]      cfg_k,
    input  logic [DW-1:0]      cfg_b,
    post_process_pipe_if.slave pif,
    output logic [15:0]        sat_cnt,
    input  logic               sat_clr
);
    localparam int FB = DW - INT_BITS;
    localparam int PW = 2 * DW;
    localparam logic [DW-1:0] DMAX  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] DMIN  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [PW-1:0] PMAX  = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] PMIN  = {1'b1, {(PW-1){1'b0}}};
    localparam logic [DW-1:0] K_ONE = DW'(1) << FB;
`ifdef POSTPROC_ROUND_EN
    localparam logic [PW:0]   RND   = (PW+1)'(1) << (FB-1);
`endif

    function automatic logic ovf_dw(input logic [DW:0] s);
        return s[DW] ^ s[DW-1];
    endfunction

    function automatic logic [DW-1:0] sat_dw(input logic [DW:0] s);
        if (s[DW] ^ s[DW-1]) return s[DW] ? DMIN : DMAX;
        return s[DW-1:0];
    endfunction

    logic [DW-1:0] tbl_bias_q [CH_DEPTH];
    logic [DW-1:0] tbl_k_q    [CH_DEPTH];
    logic [DW-1:0] tbl_b_q    [CH_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_DEPTH; i++) begin
                tbl_bias_q[i] <= '0;
                tbl_k_q[i]    <= K_ONE;
                tbl_b_q[i]    <= '0;
            end
        end else if (cfg_we) begin
            tbl_bias_q[cfg_addr] <= cfg_bias;
            tbl_k_q[cfg_addr]    <= cfg_k;
            tbl_b_q[cfg_addr]    <= cfg_b;
        end
    end

    logic en;
    logic s3_vld_q;
    assign en           = !s3_vld_q || pif.out_ready;
    assign pif.in_ready = en;

    // S1: bias add. K and B are captured with the beat so later writes never reach it.
    logic [POX-1:0][DW-1:0] in_lane;
    logic [DW-1:0]          rd_bias;
    logic [POX-1:0][DW:0]   s1_sum;
    logic [POX-1:0][DW-1:0] s1_dat_d, s1_dat_q;
    logic                   s1_sat_d, s1_sat_q, s1_vld_q;
    logic [DW-1:0]          s1_k_q, s1_b_q;
    logic [1:0]             s1_mode_q;

    assign in_lane = pif.in_data;
    assign rd_bias = tbl_bias_q[pif.in_ch];

    always_comb begin
        s1_sum   = '0;
        s1_dat_d = '0;
        s1_sat_d = 1'b0;
        for (int p = 0; p < POX; p++) begin
            s1_sum[p]   = {in_lane[p][DW-1], in_lane[p]} + {rd_bias[DW-1], rd_bias};
            s1_dat_d[p] = sat_dw(s1_sum[p]);
            s1_sat_d    = s1_sat_d | ovf_dw(s1_sum[p]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_dat_q  <= '0;
            s1_sat_q  <= 1'b0;
            s1_k_q    <= '0;
            s1_b_q    <= '0;
            s1_mode_q <= '0;
        end else if (en) begin
            s1_vld_q  <= pif.in_valid;
            s1_dat_q  <= s1_dat_d;
            s1_sat_q  <= s1_sat_d;
            s1_k_q    <= tbl_k_q[pif.in_ch];
            s1_b_q    <= tbl_b_q[pif.in_ch];
            s1_mode_q <= pif.in_mode;
        end
    end

    // S2: ReLU then full-width signed multiply by K.
    logic                   relu_on;
    logic [POX-1:0][DW-1:0] s2_x_d, s2_x_q;
    logic [POX-1:0][PW-1:0] s2_p_d, s2_p_q;
    logic                   s2_vld_q, s2_sat_q, s2_bn_q;
    logic [DW-1:0]          s2_b_q;

    assign relu_on = (s1_mode_q == 2'b00) || (s1_mode_q == 2'b11);

    always_comb begin
        s2_x_d = '0;
        s2_p_d = '0;
        for (int p = 0; p < POX; p++) begin
            s2_x_d[p] = (relu_on && s1_dat_q[p][DW-1]) ? '0 : s1_dat_q[p];
            s2_p_d[p] = {{DW{s2_x_d[p][DW-1]}}, s2_x_d[p]} * {{DW{s1_k_q[DW-1]}}, s1_k_q};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q <= 1'b0;
            s2_x_q   <= '0;
            s2_p_q   <= '0;
            s2_sat_q <= 1'b0;
            s2_bn_q  <= 1'b0;
            s2_b_q   <= '0;
        end else if (en) begin
            s2_vld_q <= s1_vld_q;
            s2_x_q   <= s2_x_d;
            s2_p_q   <= s2_p_d;
            s2_sat_q <= s1_sat_q;
            s2_bn_q  <= !s1_mode_q[1];
            s2_b_q   <= s1_b_q;
        end
    end

    // S3: rescale Q(INT_BITS) product back to DW, add B; non-BN modes pass the S2 value.
    logic [POX-1:0][PW:0]   s3_rnd;
    logic [POX-1:0][PW-1:0] s3_pw, s3_sh;
    logic [POX-1:0][DW-1:0] s3_q, s3_dat_d, s3_dat_q;
    logic [POX-1:0][DW:0]   s3_rsum;
    logic [POX-1:0]         s3_povf, s3_qovf;
    logic                   s3_sat_d, s3_sat_q;

    always_comb begin
        s3_rnd   = '0;
        s3_pw    = '0;
        s3_sh    = '0;
        s3_q     = '0;
        s3_rsum  = '0;
        s3_povf  = '0;
        s3_qovf  = '0;
        s3_dat_d = '0;
        s3_sat_d = s2_sat_q;
        for (int p = 0; p < POX; p++) begin
            s3_rnd[p] = {s2_p_q[p][PW-1], s2_p_q[p]};
`ifdef POSTPROC_ROUND_EN
            s3_rnd[p] = s3_rnd[p] + RND;
`endif
            s3_povf[p] = s3_rnd[p][PW] ^ s3_rnd[p][PW-1];
            s3_pw[p]   = s3_povf[p] ? (s3_rnd[p][PW] ? PMIN : PMAX) : s3_rnd[p][PW-1:0];
            s3_sh[p]   = $signed(s3_pw[p]) >>> FB;
            s3_qovf[p] = !((&s3_sh[p][PW-1:DW-1]) || !(|s3_sh[p][PW-1:DW-1]));
            s3_q[p]    = s3_qovf[p] ? (s3_sh[p][PW-1] ? DMIN : DMAX) : s3_sh[p][DW-1:0];
            s3_rsum[p] = {s3_q[p][DW-1], s3_q[p]} + {s2_b_q[DW-1], s2_b_q};
            if (s2_bn_q) begin
                s3_dat_d[p] = sat_dw(s3_rsum[p]);
                s3_sat_d    = s3_sat_d | s3_povf[p] | s3_qovf[p] | ovf_dw(s3_rsum[p]);
            end else begin
                s3_dat_d[p] = s2_x_q[p];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld_q <= 1'b0;
            s3_dat_q <= '0;
            s3_sat_q <= 1'b0;
        end else if (en) begin
            s3_vld_q <= s2_vld_q;
            s3_dat_q <= s3_dat_d;
            s3_sat_q <= s3_sat_d;
        end
    end

    assign pif.out_valid = s3_vld_q;
    assign pif.out_data  = s3_dat_q;

    logic [15:0] sat_cnt_d, sat_cnt_q;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (s3_vld_q && pif.out_ready && s3_sat_q && (sat_cnt_q != 16'hFFFF)) begin
            sat_cnt_d = sat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sat_cnt_q <= '0;
        else        sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
endmodule

// File: tb/tb_post_process_pipe.sv
// Bench for post_process_pipe: directed scenarios plus random traffic, scored against an integer reference model.
module tb_post_process_pipe;
    localparam int FB = 13;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [15:0] cfg_bias, cfg_k, cfg_b;
    logic [15:0] sat_cnt;
    logic        sat_clr;

    post_process_pipe_if #(.POX(3), .DW(16), .CH_AW(4)) pif ();

    post_process_pipe #(.POX(3), .DW(16), .INT_BITS(3), .CH_DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_bias (cfg_bias),
        .cfg_k    (cfg_k),
        .cfg_b    (cfg_b),
        .pif      (pif),
        .sat_cnt  (sat_cnt),
        .sat_clr  (sat_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: table, expected-beat queue, saturation counter.
    typedef struct {
        logic [47:0] d;
        bit          s;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_bias [16];
    logic [15:0] m_k    [16];
    logic [15:0] m_b    [16];
    int          m_cnt;
    int          fires;
    bit          prev_stall;
    logic [47:0] prev_dat;

    function automatic longint clamp16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic void model_lane(input logic [15:0] x, input logic [15:0] bias,
                                       input logic [15:0] k, input logic [15:0] b,
                                       input logic [1:0] mode,
                                       output logic [15:0] r, output bit s);
        longint v, p, qv, qc, rv;
        s = 0;
        v = longint'($signed(x)) + longint'($signed(bias));
        if (clamp16(v) != v) s = 1;
        v = clamp16(v);
        if ((mode == 2'b00 || mode == 2'b11) && v < 0) v = 0;
        if (mode[1]) begin
            r = 16'(v);
            return;
        end
        p = v * longint'($signed(k));
`ifdef POSTPROC_ROUND_EN
        p = p + (longint'(1) << (FB - 1));
`endif
        qv = p >>> FB;
        qc = clamp16(qv);
        if (qc != qv) s = 1;
        rv = qc + longint'($signed(b));
        if (clamp16(rv) != rv) s = 1;
        r = 16'(clamp16(rv));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            for (int i = 0; i < 16; i++) begin
                m_bias[i] = 16'h0000;
                m_k[i]    = 16'h2000;
                m_b[i]    = 16'h0000;
            end
            m_cnt      = 0;
            prev_stall = 0;
        end else begin
            exp_t        e;
            logic [15:0] r;
            bit          s, fire, fire_sat;
            check("in_ready", pif.in_ready, !pif.out_valid || pif.out_ready);
            if (prev_stall) begin
                check("hold_data", pif.out_data, prev_dat);
                check("hold_valid", pif.out_valid, 1);
            end
            check("sat_cnt", sat_cnt, m_cnt);
            prev_stall = pif.out_valid && !pif.out_ready;
            prev_dat   = pif.out_data;
            if (pif.in_valid && pif.in_ready) begin
                e.s = 0;
                for (int l = 0; l < 3; l++) begin
                    model_lane(pif.in_data[l*16 +: 16], m_bias[pif.in_ch], m_k[pif.in_ch],
                               m_b[pif.in_ch], pif.in_mode, r, s);
                    e.d[l*16 +: 16] = r;
                    e.s |= s;
                end
                sb.push_back(e);
            end
            fire     = pif.out_valid && pif.out_ready;
            fire_sat = 0;
            if (fire) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", pif.out_data, e.d);
                    fire_sat = e.s;
                    fires++;
                end
            end
            if (sat_clr) m_cnt = 0;
            else if (fire_sat && m_cnt < 65535) m_cnt++;
            if (cfg_we) begin
                m_bias[cfg_addr] = cfg_bias;
                m_k[cfg_addr]    = cfg_k;
                m_b[cfg_addr]    = cfg_b;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [15:0] bi, input logic [15:0] k,
                             input logic [15:0] b);
        cfg_we = 1; cfg_addr = a; cfg_bias = bi; cfg_k = k; cfg_b = b;
        step();
        cfg_we = 0;
    endtask

    // Presents one beat with out_ready high and returns the first output seen; any
    // pending cfg write is held for exactly the acceptance edge.
    task automatic send_wait(input logic [47:0] d, input logic [3:0] ch, input logic [1:0] mode,
                             output logic [47:0] got);
        int n;
        pif.in_valid = 1; pif.in_data = d; pif.in_ch = ch; pif.in_mode = mode; pif.out_ready = 1;
        step();
        pif.in_valid = 0;
        cfg_we = 0;
        n = 0;
        while (!pif.out_valid && n < 10) begin
            step();
            n++;
        end
        check("latency", n, 2);
        got = pif.out_data;
    endtask

    task automatic rand_beat();
        pif.in_data = {16'($urandom), 16'($urandom), 16'($urandom)};
        pif.in_ch   = 4'($urandom_range(0, 15));
        pif.in_mode = 2'($urandom_range(0, 3));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] got;
        logic [15:0] exp_rnd;
        bit          acc;
        int          n, c, bi, nexp, f0;

        rst_n = 0; cfg_we = 0; cfg_addr = 0; cfg_bias = 0; cfg_k = 0; cfg_b = 0; sat_clr = 0;
        pif.in_valid = 0; pif.in_data = '0; pif.in_ch = 0; pif.in_mode = 0; pif.out_ready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        check("rst_out_valid", pif.out_valid, 0);
        check("rst_out_data", pif.out_data, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        check("rst_in_ready", pif.in_ready, 1);

        // Default table: bias 0, K 1.0, B 0; ReLU zeroes lane 1.
        send_wait({16'h0000, 16'hFF00, 16'h0100}, 4'd0, 2'b00, got);
        check("default_entry", got, 48'h0000_0000_0100);

        // Write and read of ch 1 on the same edge: the beat still sees the old entry.
        cfg_we = 1; cfg_addr = 1; cfg_bias = 16'h0100; cfg_k = 16'h2000; cfg_b = 16'h0000;
        send_wait({16'h0000, 16'h0000, 16'h0123}, 4'd1, 2'b01, got);
        check("race_old_entry", got[15:0], 16'h0123);
        send_wait({16'h0000, 16'h0000, 16'h0123}, 4'd1, 2'b01, got);
        check("race_new_entry", got[15:0], 16'h0223);

        cfg_write(4'd2, 16'h0010, 16'h4000, 16'h0005);
        send_wait({16'h0000, 16'h0000, 16'h0020}, 4'd2, 2'b00, got);
        check("bn_relu_path", got[15:0], 16'h0065);
        send_wait({16'h0000, 16'h0000, 16'hFFF0}, 4'd2, 2'b01, got);
        check("bn_only_path", got[15:0], 16'h0005);

        cfg_write(4'd3, 16'h7FF0, 16'h2000, 16'h0000);
        sat_clr = 1;
        step();
        sat_clr = 0;
        send_wait({16'h0000, 16'h0000, 16'h0100}, 4'd3, 2'b00, got);
        check("sat_value", got[15:0], 16'h7FFF);
        step();
        check("sat_cnt_inc", sat_cnt, 1);
        send_wait({16'h0000, 16'h0000, 16'h0100}, 4'd3, 2'b00, got);
        sat_clr = 1;
        step();
        sat_clr = 0;
        check("sat_clr_wins", sat_cnt, 0);

`ifdef POSTPROC_ROUND_EN
        exp_rnd = 16'd2;
`else
        exp_rnd = 16'd1;
`endif
        cfg_write(4'd4, 16'h0000, 16'h1000, 16'h0000);
        send_wait({16'h0000, 16'h0000, 16'h0003}, 4'd4, 2'b01, got);
        check("rounding", got[15:0], exp_rnd);

        // Back-pressure: 8 beats with out_ready low for 5 cycles mid-stream.
        nexp = sb.size() + 8;
        f0 = fires;
        bi = 0; c = 0;
        pif.in_valid = 1;
        rand_beat();
        while (bi < 8 && c < 100) begin
            pif.out_ready = !(c >= 3 && c < 8);
            @(negedge clk);
            acc = pif.in_valid && pif.in_ready;
            if (c == 5) check("bp_in_ready_low", pif.in_ready, 0);
            step();
            if (acc) begin
                bi++;
                rand_beat();
            end
            c++;
        end
        pif.in_valid = 0;
        pif.out_ready = 1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        check("bp_drain", sb.size(), 0);
        check("bp_beat_count", fires - f0, nexp);

        // Reset mid-stream: in-flight beats vanish and the table reverts.
        pif.out_ready = 1;
        pif.in_valid = 1;
        repeat (4) begin
            rand_beat();
            step();
        end
        check("pre_reset_valid", pif.out_valid, 1);
        rst_n = 0;
        #1;
        check("reset_out_valid", pif.out_valid, 0);
        check("reset_out_data", pif.out_data, 0);
        check("reset_sat_cnt", sat_cnt, 0);
        pif.in_valid = 0;
        repeat (2) step();
        rst_n = 1;
        step();
        send_wait({16'h0000, 16'h0000, 16'h0123}, 4'd1, 2'b01, got);
        check("reset_table_ch1", got[15:0], 16'h0123);
        send_wait({16'h0000, 16'h0000, 16'h0100}, 4'd3, 2'b00, got);
        check("reset_table_ch3", got[15:0], 16'h0100);

        // Random traffic with stalls, config writes (often to the live channel) and clears.
        acc = 0;
        pif.in_valid = 0;
        for (int k = 0; k < 400; k++) begin
            if (!pif.in_valid || acc) begin
                pif.in_valid = ($urandom_range(0, 9) < 7);
                rand_beat();
            end
            pif.out_ready = ($urandom_range(0, 3) != 0);
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_addr = $urandom_range(0, 1) ? pif.in_ch : 4'($urandom_range(0, 15));
            cfg_bias = $urandom_range(0, 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            cfg_k    = $urandom_range(0, 1) ? 16'h2000 : 16'($urandom);
            cfg_b    = 16'($urandom);
            sat_clr  = ($urandom_range(0, 31) == 0);
            @(negedge clk);
            acc = pif.in_valid && pif.in_ready;
            step();
        end
        pif.in_valid = 0; cfg_we = 0; sat_clr = 0; pif.out_ready = 1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        step();
        check("final_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
